echo_pipeline_sequencer: RTL and testbench

- Synthesizable per-sample controller for the echo-cancellation chain: sig16b_to_double, lag_generator, para_approx / echo_cancelation, double_to_sig16b.
- Once per sampling period it issues enable pulses to each stage in order and waits for each stage's ready.
- At the end of the frame it hands the selected 64-bit double result to double_to_sig16b.
- Replaces hand-timed bench delays with a handshaked FSM and supports adaptation and cancellation modes.

---
 rtl/echo_seq_pkg.sv | 33 +++
 rtl/seq_pulse_gen.sv | 37 +++
 rtl/echo_pipeline_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_echo_pipeline_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/echo_seq_pkg.sv
// Shared definitions for the echo-cancellation chain sequencer: FSM state
// encoding, processing-mode constants, stage-select codes for the shared
// enable pulse generator and the double-precision word width.
package echo_seq_pkg;

  localparam int DOUBLE_W = 64;

  localparam logic MODE_ADAPT  = 1'b1;
  localparam logic MODE_CANCEL = 1'b0;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t CONV   = 3'd1;
  localparam state_t W_CONV = 3'd2;
  localparam state_t LAG    = 3'd3;
  localparam state_t W_LAG  = 3'd4;
  localparam state_t PROC   = 3'd5;
  localparam state_t W_PROC = 3'd6;
  localparam state_t OUT    = 3'd7;

  // Which of the four pulsed stage enables the shared generator drives.
  localparam logic [1:0] SEL_CONV   = 2'd0;
  localparam logic [1:0] SEL_LAG    = 2'd1;
  localparam logic [1:0] SEL_ADAPT  = 2'd2;
  localparam logic [1:0] SEL_CANCEL = 2'd3;

  // Processing stage chosen by the latched frame mode.
  function automatic logic [1:0] proc_sel(input logic mode);
    return (mode == MODE_ADAPT) ? SEL_ADAPT : SEL_CANCEL;
  endfunction

endpackage

// File: rtl/seq_pulse_gen.sv
// Shared enable pulse generator. A start strobe loads a down-counter and
// raises one registered, one-hot enable chosen by sel for PULSE cycles.
// last is high during the final cycle of the pulse so the controller can
// leave the pulse state on the same edge the enable drops.
module seq_pulse_gen
  import echo_seq_pkg::*;
#(
  parameter int PULSE = 2
) (
  input  logic       clk_operation,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] sel,
  output logic [3:0] en,
  output logic       last
);

  logic [3:0] cnt;

  assign last = (en != 4'b0000) && (cnt == 4'd0);

  // Load on start, count the pulse down, then drop the enable.
  always_ff @(posedge clk_operation or negedge rst) begin
    if (!rst) begin
      cnt <= 4'd0;
      en  <= 4'b0000;
    end else if (start) begin
      cnt <= 4'(PULSE - 1);
      en  <= 4'b0001 << sel;
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end else begin
      en <= 4'b0000;
    end
  end

endmodule

// File: rtl/echo_pipeline_sequencer.sv
// Per-sample controller for the echo-cancellation chain
// (sig16b_to_double -> lag_generator -> para_approx / echo_cancelation ->
// double_to_sig16b). Optional build macro: SEQ_TIMEOUT_EN adds a watchdog to
// every wait state that abandons the frame after TIMEOUT cycles.
//
// Handshake: each stage gets a registered enable pulse of ENABLE_PULSE cycles;
// the stage answers by raising its ready flag. Only a 0->1 transition of
// ready that is sampled after the enable has dropped advances the sequence; a
// ready that is already high must fall and rise again. enable_mut5 is a single
// cycle strobe qualifying double_mut5 and carries no return handshake.
module echo_pipeline_sequencer
  import echo_seq_pkg::*;
#(
  parameter int CNT_W        = 13,
  parameter int ENABLE_PULSE = 2,
  parameter int TIMEOUT      = 2048
) (
  input  logic                clk_operation,
  input  logic                rst,
  input  logic [CNT_W-1:0]    sampling_cycle_counter,
  input  logic                enable_para_approx,
  input  logic                ready_mut1,
  input  logic                ready_mut2,
  input  logic                ready_mut3,
  input  logic                ready_mut4,
  input  logic [DOUBLE_W-1:0] e,
  input  logic [DOUBLE_W-1:0] signal_without_echo,
  input  logic                err_clr,
  output logic                enable_mut1,
  output logic                enable_mut2,
  output logic                enable_mut3,
  output logic                enable_mut4,
  output logic                enable_mut5,
  output logic [DOUBLE_W-1:0] double_mut5,
  output logic [31:0]         iteration,
  output logic                busy,
  output logic                timeout_err,
  output logic                overrun,
  output logic [2:0]          fsm_state
);

  state_t     state;
  state_t     state_next;
  logic       mode;
  logic [3:0] ready_now;
  logic [3:0] ready_q;
  logic [3:0] rise;
  logic       proc_rise;
  logic       trigger;
  logic       pg_start;
  logic [1:0] pg_sel;
  logic [3:0] pg_en;
  logic       pg_last;
  logic       out_fire;
  logic       enter_wait;
  logic       timeout_hit;
  logic       wd_expired;

  assign ready_now = {ready_mut4, ready_mut3, ready_mut2, ready_mut1};
  assign rise      = ready_now & ~ready_q;
  assign proc_rise = (mode == MODE_ADAPT) ? rise[2] : rise[3];
  assign trigger   = (sampling_cycle_counter == '0);
  assign busy      = (state != IDLE);
  assign fsm_state = state;

  assign enable_mut1 = pg_en[0];
  assign enable_mut2 = pg_en[1];
  assign enable_mut3 = pg_en[2];
  assign enable_mut4 = pg_en[3];

  seq_pulse_gen #(
    .PULSE (ENABLE_PULSE)
  ) u_pulse (
    .clk_operation (clk_operation),
    .rst           (rst),
    .start         (pg_start),
    .sel           (pg_sel),
    .en            (pg_en),
    .last          (pg_last)
  );

  // Next-state logic: pulse a stage, wait for its ready edge, move on.
  always_comb begin
    state_next  = state;
    pg_start    = 1'b0;
    pg_sel      = SEL_CONV;
    out_fire    = 1'b0;
    enter_wait  = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (trigger) begin
          state_next = CONV;
          pg_start   = 1'b1;
          pg_sel     = SEL_CONV;
        end
      end
      CONV: begin
        if (pg_last) begin
          state_next = W_CONV;
          enter_wait = 1'b1;
        end
      end
      W_CONV: begin
        if (rise[0]) begin
          state_next = LAG;
          pg_start   = 1'b1;
          pg_sel     = SEL_LAG;
        end else if (wd_expired) begin
          state_next  = IDLE;
          timeout_hit = 1'b1;
        end
      end
      LAG: begin
        if (pg_last) begin
          state_next = W_LAG;
          enter_wait = 1'b1;
        end
      end
      W_LAG: begin
        if (rise[1]) begin
          state_next = PROC;
          pg_start   = 1'b1;
          pg_sel     = proc_sel(mode);
        end else if (wd_expired) begin
          state_next  = IDLE;
          timeout_hit = 1'b1;
        end
      end
      PROC: begin
        if (pg_last) begin
          state_next = W_PROC;
          enter_wait = 1'b1;
        end
      end
      W_PROC: begin
        if (proc_rise) begin
          state_next = OUT;
          out_fire   = 1'b1;
        end else if (wd_expired) begin
          state_next  = IDLE;
          timeout_hit = 1'b1;
        end
      end
      OUT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, ready history for edge detection, and the per-frame mode latch.
  always_ff @(posedge clk_operation or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      mode    <= MODE_CANCEL;
      ready_q <= 4'b0000;
    end else begin
      state   <= state_next;
      ready_q <= ready_now;
      if (state == IDLE && trigger) begin
        mode <= enable_para_approx;
      end
    end
  end

  // Result hand-off: strobe, held result word and completed-frame count.
  always_ff @(posedge clk_operation or negedge rst) begin
    if (!rst) begin
      enable_mut5 <= 1'b0;
      double_mut5 <= '0;
      iteration   <= 32'd0;
    end else begin
      enable_mut5 <= out_fire;
      if (out_fire) begin
        double_mut5 <= (mode == MODE_ADAPT) ? e : signal_without_echo;
        iteration   <= iteration + 32'd1;
      end
    end
  end

  // Sticky overrun: a frame start arrived while a frame was still running.
  always_ff @(posedge clk_operation or negedge rst) begin
    if (!rst) begin
      overrun <= 1'b0;
    end else if (trigger && busy) begin
      overrun <= 1'b1;
    end else if (err_clr) begin
      overrun <= 1'b0;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd;
  logic            wait_state;

  assign wait_state = (state == W_CONV) || (state == W_LAG) || (state == W_PROC);
  assign wd_expired = wait_state && (wd == WD_W'(TIMEOUT - 1));

  // Watchdog restarts on entry to every wait state.
  always_ff @(posedge clk_operation or negedge rst) begin
    if (!rst) begin
      wd <= '0;
    end else if (enter_wait) begin
      wd <= '0;
    end else if (wait_state) begin
      wd <= wd + 1'b1;
    end
  end

  // Sticky timeout flag; a new timeout wins over a simultaneous clear.
  always_ff @(posedge clk_operation or negedge rst) begin
    if (!rst) begin
      timeout_err <= 1'b0;
    end else if (timeout_hit) begin
      timeout_err <= 1'b1;
    end else if (err_clr) begin
      timeout_err <= 1'b0;
    end
  end
`else
  logic unused_wd;

  assign wd_expired  = 1'b0;
  assign timeout_err = 1'b0;
  assign unused_wd   = timeout_hit | enter_wait | (TIMEOUT != 0);
`endif

endmodule

// File: tb/tb_echo_pipeline_sequencer.sv
// Self-checking bench for echo_pipeline_sequencer. Frames are driven by
// tasks; a reference model queues the expected enable order and the expected
// {iteration, result} word per frame, and a monitor compares them as the DUT
// raises its enables. Build with SEQ_TIMEOUT_EN to exercise the watchdog.
module tb_echo_pipeline_sequencer;

  localparam int PULSE = 2;
  localparam int TO    = 16;
`ifdef SEQ_TIMEOUT_EN
  localparam int LAT_A = 8;
  localparam int LAT_B = 10;
  localparam int LAT_C = 12;
  localparam int LAT_MAX = 10;
`else
  localparam int LAT_A = 8;
  localparam int LAT_B = 600;
  localparam int LAT_C = 1200;
  localparam int LAT_MAX = 20;
`endif

  // Clock and reset
  logic clk_operation = 1'b0;
  always #5 clk_operation = ~clk_operation;

  logic        rst;
  logic [12:0] sampling_cycle_counter;
  logic        enable_para_approx;
  logic        ready_mut1, ready_mut2, ready_mut3, ready_mut4;
  logic [63:0] e, signal_without_echo;
  logic        err_clr;
  logic        enable_mut1, enable_mut2, enable_mut3, enable_mut4, enable_mut5;
  logic [63:0] double_mut5;
  logic [31:0] iteration;
  logic        busy, timeout_err, overrun;
  logic [2:0]  fsm_state;

  echo_pipeline_sequencer #(
    .CNT_W        (13),
    .ENABLE_PULSE (PULSE),
    .TIMEOUT      (TO)
  ) dut (
    .clk_operation          (clk_operation),
    .rst                    (rst),
    .sampling_cycle_counter (sampling_cycle_counter),
    .enable_para_approx     (enable_para_approx),
    .ready_mut1             (ready_mut1),
    .ready_mut2             (ready_mut2),
    .ready_mut3             (ready_mut3),
    .ready_mut4             (ready_mut4),
    .e                      (e),
    .signal_without_echo    (signal_without_echo),
    .err_clr                (err_clr),
    .enable_mut1            (enable_mut1),
    .enable_mut2            (enable_mut2),
    .enable_mut3            (enable_mut3),
    .enable_mut4            (enable_mut4),
    .enable_mut5            (enable_mut5),
    .double_mut5            (double_mut5),
    .iteration              (iteration),
    .busy                   (busy),
    .timeout_err            (timeout_err),
    .overrun                (overrun),
    .fsm_state              (fsm_state)
  );

  // Scoreboard state and reference model
  int          tests = 0;
  int          fails = 0;
  logic [95:0] exp_q[$];
  int          exp_en_q[$];
  logic [31:0] model_iter = 32'd0;
  logic        model_ovr = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic en_bit(input int idx);
    case (idx)
      1: return enable_mut1;
      2: return enable_mut2;
      3: return enable_mut3;
      4: return enable_mut4;
      default: return enable_mut5;
    endcase
  endfunction

  // Driver tasks
  task automatic tick();
    @(negedge clk_operation);
    sampling_cycle_counter = 13'($urandom_range(1, 8191));
  endtask

  task automatic set_ready(input int idx, input logic v);
    case (idx)
      1: ready_mut1 = v;
      2: ready_mut2 = v;
      3: ready_mut3 = v;
      default: ready_mut4 = v;
    endcase
  endtask

  task automatic wait_en(input int idx, input logic val, input int budget);
    int n = 0;
    while (en_bit(idx) !== val && n < budget) begin
      tick();
      n++;
    end
    check($sformatf("wait_enable_mut%0d_to_%0d", idx, val), 128'(en_bit(idx)), 128'(val));
  endtask

  // Idle for n cycles; no stage may be enabled while its predecessor waits.
  task automatic hold_quiet(input int n);
    logic seen = 1'b0;
    repeat (n) begin
      tick();
      if ({enable_mut1, enable_mut2, enable_mut3, enable_mut4, enable_mut5} != 5'b0) seen = 1'b1;
    end
    check("no_early_advance", 128'(seen), 128'(0));
  endtask

  task automatic stage(input int idx, input int lat);
    wait_en(idx, 1'b1, 20);
    wait_en(idx, 1'b0, 20);
    hold_quiet(lat);
    set_ready(idx, 1'b1);
  endtask

  task automatic clear_errors();
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    model_ovr = 1'b0;
    check("err_clr_overrun", 128'(overrun), 128'(0));
  endtask

  task automatic run_frame(input logic mode, input logic [63:0] ev, input logic [63:0] sv,
                           input int l1, input int l2, input int l3,
                           input bit toggle, input int ovr, input bit early2);
    logic [63:0] res;
    ready_mut1 = 1'b0; ready_mut2 = 1'b0; ready_mut3 = 1'b0; ready_mut4 = 1'b0;
    e = ev;
    signal_without_echo = sv;
    enable_para_approx = mode;
    tick();
    res = mode ? ev : sv;
    exp_en_q.push_back(1);
    exp_en_q.push_back(2);
    exp_en_q.push_back(mode ? 3 : 4);
    exp_en_q.push_back(5);
    model_iter = model_iter + 32'd1;
    exp_q.push_back({model_iter, res});
    sampling_cycle_counter = '0;
    stage(1, l1);
    if (early2) ready_mut2 = 1'b1;
    wait_en(2, 1'b1, 20);
    wait_en(2, 1'b0, 20);
    if (early2) begin
      hold_quiet(3);
      ready_mut2 = 1'b0;
    end
    if (toggle) enable_para_approx = ~mode;
    if (ovr != 0) begin
      sampling_cycle_counter = '0;
      err_clr = (ovr == 2);
      tick();
      err_clr = 1'b0;
      model_ovr = 1'b1;
      check("overrun_set", 128'(overrun), 128'(1));
    end
    hold_quiet((early2 && l2 < 1) ? 1 : l2);
    set_ready(2, 1'b1);
    stage(mode ? 3 : 4, l3);
    wait_en(5, 1'b1, 20);
    wait_en(5, 1'b0, 20);
    hold_quiet(2);
    check("result_hold", 128'(double_mut5), 128'(res));
    check("iteration", 128'(iteration), 128'(model_iter));
    check("busy_idle", 128'(busy), 128'(0));
    check("overrun_flag", 128'(overrun), 128'(model_ovr));
  endtask

  // Monitor: enable ordering, one-hot, pulse lengths and result words
  logic [4:0] prev_vec = 5'b0;
  int         run_len[5];

  always @(negedge clk_operation) begin
    logic [4:0] v;
    v = {enable_mut5, enable_mut4, enable_mut3, enable_mut2, enable_mut1};
    if (!rst) begin
      prev_vec = 5'b0;
      for (int i = 0; i < 5; i++) run_len[i] = 0;
    end else begin
      check("one_hot_enables", 128'($countones(v) <= 1), 128'(1));
      for (int i = 0; i < 5; i++) begin
        if (v[i] && !prev_vec[i]) begin
          run_len[i] = 0;
          if (exp_en_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL enable_order: got enable_mut%0d required none", i + 1);
          end else begin
            check("enable_order", 128'(i + 1), 128'(exp_en_q.pop_front()));
          end
          if (i == 4) begin
            if (exp_q.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL result: got %0h required no output", double_mut5);
            end else begin
              check("result", 128'({iteration, double_mut5}), 128'(exp_q.pop_front()));
            end
          end
        end
        if (v[i]) run_len[i]++;
        if (!v[i] && prev_vec[i]) check($sformatf("pulse_len_mut%0d", i + 1), 128'(run_len[i]), 128'((i == 4) ? 1 : PULSE));
      end
      prev_vec = v;
    end
  end

  // Main sequence
  initial begin
    rst = 1'b0;
    sampling_cycle_counter = 13'd1;
    enable_para_approx = 1'b0;
    ready_mut1 = 1'b0; ready_mut2 = 1'b0; ready_mut3 = 1'b0; ready_mut4 = 1'b0;
    e = '0;
    signal_without_echo = '0;
    err_clr = 1'b0;
    repeat (3) tick();
    check("reset_outputs", 128'({enable_mut1, enable_mut2, enable_mut3, enable_mut4, enable_mut5,
                                 double_mut5, iteration, busy, overrun, timeout_err}), 128'(0));
    rst = 1'b1;
    tick();

    // Adapt then cancel with the documented result words
    run_frame(1'b1, 64'h3FE0000000000000, {$urandom, $urandom}, LAT_A, LAT_B, LAT_C, 1'b0, 0, 1'b0);
    run_frame(1'b0, {$urandom, $urandom}, 64'hBFF0000000000000, 3, 5, 7, 1'b0, 0, 1'b0);

    // Mode flips during W_LAG: this frame adapts, the next one cancels
    run_frame(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 2, 6, 2, 1'b1, 0, 1'b0);
    run_frame(1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 2, 2, 2, 1'b0, 0, 1'b0);

    // Ready already high when the LAG pulse starts; zero-latency readies
    run_frame(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 0, 2, 0, 1'b0, 0, 1'b1);

    // Overrun (with a mode flip), then overrun coinciding with err_clr
    run_frame(1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1, 4, 1, 1'b1, 1, 1'b0);
    clear_errors();
    run_frame(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1, 3, 1, 1'b0, 2, 1'b0);
    clear_errors();

    // Randomized frames
    for (int k = 0; k < 8; k++) begin
      run_frame(1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
                $urandom_range(0, LAT_MAX), $urandom_range(0, LAT_MAX), $urandom_range(0, LAT_MAX),
                1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)));
    end

`ifdef SEQ_TIMEOUT_EN
    // ready_mut1 never rises: watchdog abandons the frame
    ready_mut1 = 1'b0; ready_mut2 = 1'b0; ready_mut3 = 1'b0; ready_mut4 = 1'b0;
    enable_para_approx = 1'b1;
    tick();
    exp_en_q.push_back(1);
    sampling_cycle_counter = '0;
    wait_en(1, 1'b1, 20);
    wait_en(1, 1'b0, 20);
    repeat (TO - 1) tick();
    check("timeout_before", 128'(timeout_err), 128'(0));
    tick();
    check("timeout_at_limit", 128'(timeout_err), 128'(1));
    check("timeout_idle", 128'(busy), 128'(0));
    hold_quiet(3);
    check("timeout_iteration", 128'(iteration), 128'(model_iter));
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("timeout_clr", 128'(timeout_err), 128'(0));
`else
    check("timeout_tied", 128'(timeout_err), 128'(0));
`endif

    // Asynchronous reset while enable_mut3 is high
    ready_mut1 = 1'b0; ready_mut2 = 1'b0; ready_mut3 = 1'b0; ready_mut4 = 1'b0;
    enable_para_approx = 1'b1;
    tick();
    exp_en_q.push_back(1);
    exp_en_q.push_back(2);
    exp_en_q.push_back(3);
    sampling_cycle_counter = '0;
    stage(1, 2);
    stage(2, 2);
    wait_en(3, 1'b1, 20);
    #2 rst = 1'b0;
    #1;
    check("reset_cuts_enable3", 128'(enable_mut3), 128'(0));
    check("reset_mid_outputs", 128'({enable_mut1, enable_mut2, enable_mut3, enable_mut4, enable_mut5,
                                     double_mut5, iteration, busy, overrun, timeout_err}), 128'(0));
    exp_q.delete();
    exp_en_q.delete();
    model_iter = 32'd0;
    model_ovr = 1'b0;
    ready_mut1 = 1'b0; ready_mut2 = 1'b0; ready_mut3 = 1'b0; ready_mut4 = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    run_frame(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 2, 2, 2, 1'b0, 0, 1'b0);

    // Report
    check("exp_q_drained", 128'(exp_q.size()), 128'(0));
    check("exp_en_q_drained", 128'(exp_en_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    fails++;
    $display("FAIL global_timeout: got simulation still running required completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
